// File: rtl/execute_mc_if.sv
// Execute-stage bundle: E-register operands and downstream status in, e_* results,
// condition codes and the multiplier stall request out.
interface execute_mc_if #(
    parameter int WIDTH = 64
);
    logic             E_valid;
    logic [3:0]       E_stat;
    logic [3:0]       E_icode;
    logic [3:0]       E_ifun;
    logic [WIDTH-1:0] E_valC;
    logic [WIDTH-1:0] E_valA;
    logic [WIDTH-1:0] E_valB;
    logic [3:0]       E_dstE;
    logic [3:0]       E_dstM;
    logic [3:0]       m_stat;
    logic [3:0]       W_stat;

    logic [3:0]       e_stat;
    logic [3:0]       e_icode;
    logic [WIDTH-1:0] e_valE;
    logic [WIDTH-1:0] e_valA;
    logic [3:0]       e_dstE;
    logic [3:0]       e_dstM;
    logic             e_Cnd;
    logic             cc_zf;
    logic             cc_sf;
    logic             cc_of;
    logic             e_busy;

    modport master (
        output E_valid, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
               m_stat, W_stat,
        input  e_stat, e_icode, e_valE, e_valA, e_dstE, e_dstM, e_Cnd,
               cc_zf, cc_sf, cc_of, e_busy
    );

    modport slave (
        input  E_valid, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
               m_stat, W_stat,
        output e_stat, e_icode, e_valE, e_valA, e_dstE, e_dstM, e_Cnd,
               cc_zf, cc_sf, cc_of, e_busy
    );
endinterface

// File: rtl/execute_mc.sv
// Y-86 execute stage: combinational ALU and condition logic, condition-code register,
// and an iterative shift-add signed multiplier for mulq that stalls via e_busy.
module execute_mc #(
    parameter int WIDTH  = 64,
    parameter bit MUL_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    execute_mc_if.slave bus
);

    localparam logic [3:0] S_AOK    = 4'b1000;
    localparam logic [3:0] S_INS    = 4'b0001;
    localparam logic [3:0] REG_NONE = 4'hF;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOV  = 4'h3;
    localparam logic [3:0] I_RMMOV  = 4'h4;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_OP     = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSH   = 4'hA;
    localparam logic [3:0] I_POP    = 4'hB;
    localparam int         CW       = $clog2(WIDTH);
    localparam int         MSB      = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;

    mul_state_t           state, state_nx;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mcand, mplier;
    logic                 mul_neg;
    logic [CW-1:0]        count;
    logic                 mul_start, mul_step;

    logic                 is_op, is_mul, op_illegal, stat_ok, cond, cnd;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_of;
    logic [2*WIDTH-1:0]   mul_prod;
    logic [WIDTH-1:0]     mul_lo;
    logic                 mul_of;
    logic [WIDTH:0]       add_sum;

    assign is_op      = bus.E_valid && (bus.E_icode == I_OP);
    assign is_mul     = is_op && (bus.E_ifun == 4'd4) && MUL_EN;
    assign op_illegal = is_op && ((bus.E_ifun > 4'd4) || ((bus.E_ifun == 4'd4) && !MUL_EN));
    assign stat_ok    = (bus.m_stat == S_AOK) && (bus.W_stat == S_AOK);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cond = 1'b0;
        case (bus.E_ifun)
            4'd0:    cond = 1'b1;
            4'd1:    cond = (bus.cc_sf ^ bus.cc_of) | bus.cc_zf;
            4'd2:    cond = bus.cc_sf ^ bus.cc_of;
            4'd3:    cond = bus.cc_zf;
            4'd4:    cond = !bus.cc_zf;
            4'd5:    cond = !(bus.cc_sf ^ bus.cc_of);
            4'd6:    cond = !(bus.cc_sf ^ bus.cc_of) && !bus.cc_zf;
            default: cond = 1'b0;
        endcase
    end

    assign cnd = bus.E_valid && ((bus.E_icode == I_CMOV) || (bus.E_icode == I_JXX)) && cond;

    always_comb begin
        alu_res = '0;
        alu_of  = 1'b0;
        case (bus.E_icode)
            I_CMOV:           alu_res = bus.E_valA;
            I_IRMOV:          alu_res = bus.E_valC;
            I_RMMOV, I_MRMOV: alu_res = bus.E_valB + bus.E_valC;
            I_CALL, I_PUSH:   alu_res = bus.E_valB - WIDTH'(8);
            I_RET, I_POP:     alu_res = bus.E_valB + WIDTH'(8);
            I_OP: begin
                case (bus.E_ifun)
                    4'd0: begin
                        alu_res = bus.E_valB + bus.E_valA;
                        alu_of  = (bus.E_valA[MSB] == bus.E_valB[MSB]) && (alu_res[MSB] != bus.E_valB[MSB]);
                    end
                    4'd1: begin
                        alu_res = bus.E_valB - bus.E_valA;
                        alu_of  = (bus.E_valA[MSB] != bus.E_valB[MSB]) && (alu_res[MSB] != bus.E_valB[MSB]);
                    end
                    4'd2:    alu_res = bus.E_valB & bus.E_valA;
                    4'd3:    alu_res = bus.E_valB ^ bus.E_valA;
                    default: alu_res = '0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

    // Magnitudes are multiplied unsigned; the sign is re-applied to the full 2*WIDTH product.
    assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : '0)};
    assign mul_prod = mul_neg ? -acc : acc;
    assign mul_lo   = mul_prod[WIDTH-1:0];
    assign mul_of   = mul_prod[2*WIDTH-1:WIDTH] != {WIDTH{mul_prod[MSB]}};

    always_comb begin
        state_nx  = state;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        case (state)
            IDLE: if (is_mul) begin
                state_nx  = RUN;
                mul_start = 1'b1;
            end
            RUN: if (!is_mul) begin
                state_nx = IDLE;
            end else begin
                mul_step = 1'b1;
                if (count == CW'(WIDTH - 1)) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: the multiplier datapath is reset too, so a fresh core never exposes stale operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            mul_neg <= 1'b0;
            count   <= '0;
        end else if (mul_start) begin
            acc     <= '0;
            mcand   <= bus.E_valB[MSB] ? -bus.E_valB : bus.E_valB;
            mplier  <= bus.E_valA[MSB] ? -bus.E_valA : bus.E_valA;
            mul_neg <= bus.E_valB[MSB] ^ bus.E_valA[MSB];
            count   <= '0;
        end else if (mul_step) begin
            acc     <= {add_sum, acc[WIDTH-1:1]};
            mplier  <= mplier >> 1;
            count   <= count + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.cc_zf <= 1'b1;
            bus.cc_sf <= 1'b0;
            bus.cc_of <= 1'b0;
        end else if ((state == DONE) && is_mul && stat_ok) begin
            bus.cc_zf <= (mul_lo == '0);
            bus.cc_sf <= mul_lo[MSB];
            bus.cc_of <= mul_of;
        end else if (is_op && (bus.E_ifun < 4'd4) && stat_ok) begin
            bus.cc_zf <= (alu_res == '0);
            bus.cc_sf <= alu_res[MSB];
            bus.cc_of <= alu_of;
        end
    end

    assign bus.e_busy  = !rst && is_mul && (state != DONE);
    assign bus.e_stat  = op_illegal ? S_INS : bus.E_stat;
    assign bus.e_icode = bus.E_valid ? bus.E_icode : I_NOP;
    assign bus.e_valA  = bus.E_valA;
    assign bus.e_dstM  = bus.E_valid ? bus.E_dstM : REG_NONE;
    assign bus.e_Cnd   = cnd;
    assign bus.e_valE  = !bus.E_valid ? '0 :
                         is_mul       ? ((state == DONE) ? mul_lo : '0) : alu_res;
    assign bus.e_dstE  = (!bus.E_valid || op_illegal)                ? REG_NONE :
                         ((bus.E_icode == I_CMOV) && !cnd)            ? REG_NONE : bus.E_dstE;

endmodule

// File: doc/execute_mc.md
# execute_mc

Parametrised execute stage for the pipelined Y-86 core, sitting between the E and M pipeline registers. It evaluates ALU operations and cmovXX/jXX conditions, holds the condition-code register, and steers e_dstE. It adds two capabilities to single-cycle execute:
- an iterative signed multiplier (`mulq`, OPq ifun 4) that stalls the pipeline through a busy handshake;
- explicit bubble/flush handling.

## Interface
Parameters:
- WIDTH, 64: datapath width for valC/valA/valB/valE; legal range 8..64.
- MUL_EN, 1: 1 enables `mulq`; 0 makes OPq ifun 4 an illegal instruction.

Ports:
- clk  in  1  pipeline clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- E_valid  in  1  1 = E register holds a real instruction; 0 = bubble.
- E_stat, E_icode, E_ifun  in  4 each  status, opcode and function from the E register.
- E_valC, E_valA, E_valB  in  WIDTH each  operands from the E register.
- E_dstE, E_dstM  in  4 each  destination register IDs; 15 = none.
- m_stat, W_stat  in  4 each  status of the instructions in M and W.
- e_stat, e_icode  out  4 each  forwarded status and opcode.
- e_valE, e_valA  out  WIDTH each  ALU result and pass-through valA.
- e_dstE, e_dstM  out  4 each  destinations after cmov squash.
- e_Cnd  out  1  condition result for cmovXX/jXX.
- cc_zf, cc_sf, cc_of  out  1 each  registered condition codes.
- e_busy  out  1  stall request; while high, hazard control holds F/D/E and injects a bubble into M.

## Operation
- Status encoding: AOK = 4'b1000, INS = 4'b0001.
- Bubble (E_valid = 0):
  - e_icode = 1 (nop); e_dstE = e_dstM = 15; e_Cnd = 0; e_valE = 0.
  - No CC write; multiplier FSM forced to IDLE.
- ALU operand/function selection (combinational, result is e_valE):
  - cmov: valA + 0.
  - irmovq: valC + 0.
  - rmmovq/mrmovq: valB + valC.
  - call/pushq: valB - 8.
  - ret/popq: valB + 8.
  - OPq ifun 0..3: valB op valA, with op = add / sub (valB-valA) / and / xor.
  - All other icodes: e_valE = 0.
- OPq with ifun > 4, or ifun 4 when MUL_EN = 0:
  - e_stat = INS, no CC write, e_dstE = 15.
- Conditions, evaluated from cc_*:
  - ifun 0 always; 1 le = (SF^OF)|ZF; 2 l = SF^OF; 3 e = ZF; 4 ne = !ZF; 5 ge = !(SF^OF); 6 g = !(SF^OF)&!ZF; ifun > 6 gives 0.
  - e_Cnd is 0 for icodes other than 2 and 7.
  - cmov with e_Cnd = 0 drives e_dstE = 15.
- CC write enable = E_valid & icode 6 & legal ifun & m_stat == AOK & W_stat == AOK.
  - ZF = (result == 0); SF = result[WIDTH-1].
  - OF for add: operand signs equal and result sign differs.
  - OF for sub (valB-valA): signs of valB and valA differ and result sign differs from valB.
  - OF for and/xor: 0.
- Multiplier FSM, states IDLE, RUN, DONE:
  - IDLE → RUN when a valid mulq is in E. On that edge, latch |valB|, |valA| and sign = valB^valA, and clear the 2·WIDTH-bit accumulator and the iteration counter.
  - RUN performs one shift-add step per cycle. After WIDTH steps it goes to DONE.
  - DONE drives e_valE = low WIDTH bits of the sign-corrected product. OF = 1 when the upper WIDTH bits are not a sign extension of bit WIDTH-1.
  - CC is written on the DONE edge, gated by the same m_stat/W_stat condition. DONE → IDLE.
  - e_busy = mulq in E & state != DONE.
  - e_valE = 0 while busy.
- Abort: E_valid falling while in RUN sends the FSM to IDLE on the next edge, with no CC write and e_busy deasserting combinationally.

## Timing
- Non-mul paths are combinational from the E register: e_valE/e_Cnd/e_dst* are valid the same cycle. CC update is visible the cycle after.
- mulq timeline, with E holding mulq from cycle 0:
  - cycle 0 IDLE, busy = 1;
  - cycles 1..WIDTH RUN, busy = 1;
  - cycle WIDTH+1 DONE, busy = 0, e_valE valid.
  - Busy lasts WIDTH+1 cycles; the result is captured by M at the end of cycle WIDTH+1.
- Back-to-back mulq: the second one enters IDLE at cycle WIDTH+2 and starts a fresh sequence.
- During reset:
  - cc_zf = 1, cc_sf = 0, cc_of = 0; FSM IDLE; counter/accumulator 0.
  - e_busy = 0 while rst is high.
  - Other outputs follow the combinational rules above.
- Reset asserted mid-RUN clears the FSM immediately (asynchronously). No partial result is committed.
- CC write and a new mulq start never coincide: DONE has priority, and IDLE is re-entered first.

## Test plan
- WIDTH=64 addq, valA = 0x7FFF_FFFF_FFFF_FFFF, valB = 1, m_stat = W_stat = AOK → e_valE = 0x8000_0000_0000_0000; next cycle ZF=0, SF=1, OF=1.
- subq valA = valB = 5, then jle ifun 1 → e_valE = 0, ZF=1, e_Cnd=1. Repeat with m_stat = INS → CC unchanged, e_Cnd follows the old CC.
- cmovne ifun 4 with ZF=1, E_dstE=3 → e_Cnd=0, e_dstE=15, e_valE = valA.
- mulq valB = 6, valA = -7 → e_busy high for exactly 65 cycles, then e_valE = -42, SF=1, OF=0. Also 2^40 × 2^40 → OF=1.
- During RUN: drop E_valid at iteration 10 → busy low immediately, FSM IDLE next edge, CC unchanged. Separately, assert rst at iteration 20 → busy 0, cc = {1,0,0}.
- Parameter sweep WIDTH=16, MUL_EN=0: addq 0x7FFF+1 → 0x8000, OF=1. mulq → e_stat = INS, e_busy never asserts.
